// File: rtl/sample_valid_pipe.sv
// sample_valid_pipe: valid/ready pipeline adding ADDEND to in_data; occupancy counter under SAMPLE_VALID_PIPE_OCC_EN
module sample_valid_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int ADDEND = 42
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             flush,
    output logic                             output_valid,
    input  logic                             output_ready,
`ifdef SAMPLE_VALID_PIPE_OCC_EN
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
`endif
    output logic [WIDTH-1:0]                 out
);
    localparam logic [WIDTH-1:0] ADD = WIDTH'(ADDEND);
    logic [STAGES-1:0] v, adv, up_v;
    logic [WIDTH-1:0]  d    [STAGES];
    logic [WIDTH-1:0]  up_d [STAGES];
    logic              accept;
    assign input_ready  = ~rst_n | (adv[0] & ~flush);
    assign accept       = rst_n & input_valid & input_ready;
    assign output_valid = v[STAGES-1];
    assign out          = d[STAGES-1];
    // a stage may move when its successor moves or it holds nothing
    always_comb begin
        adv[STAGES-1] = output_ready | ~v[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) adv[i] = adv[i+1] | ~v[i];
    end
    // upstream feed of each stage: the adder for stage 0, the previous stage otherwise
    always_comb begin
        up_v[0] = accept;
        up_d[0] = in_data + ADD;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end
    // stage registers: flush drops valids only, data loads only with a valid item
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush) v[i] <= 1'b0;
                else if (adv[i]) v[i] <= up_v[i];
                if (!flush && adv[i] && up_v[i]) d[i] <= up_d[i];
            end
        end
    end
`ifdef SAMPLE_VALID_PIPE_OCC_EN
    logic xfer;
    assign xfer = v[STAGES-1] & output_ready;
    // count of items held: up on accept, down on output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occupancy <= '0;
        else if (flush) occupancy <= '0;
        else if (accept && !xfer) occupancy <= occupancy + 1'b1;
        else if (xfer && !accept) occupancy <= occupancy - 1'b1;
    end
`endif
endmodule

// File: doc/sample_valid_pipe.md
SAMPLE_VALID_PIPE -- requirements
Module: sample_valid_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, legal 1..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline register stages, legal 1..16.
REQ-003 SHALL have parameter ADDEND, default 42: constant added to input data, truncated to WIDTH bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port input_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port input_ready, output, 1 bit: the block accepts input this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: operand.
REQ-009 SHALL have port flush, input, 1 bit: synchronous invalidation of all stages.
REQ-010 SHALL have port output_valid, output, 1 bit: out is valid.
REQ-011 SHALL have port output_ready, input, 1 bit: the consumer accepts out this cycle.
REQ-012 SHALL have port out, output, WIDTH bits: result.
REQ-013 SHALL have port occupancy, output, $clog2(STAGES+1) bits: number of valid stages (present only per REQ-035).

Function
REQ-014 SHALL compute each result as (in_data + ADDEND) mod 2^WIDTH before the stage-0 register; later stages only move data.
REQ-015 SHALL hold STAGES stages, each with a valid bit v[i] and a data register d[i]; out = d[STAGES-1] and output_valid = v[STAGES-1].
REQ-016 SHALL define advance[STAGES-1] = output_ready | ~v[STAGES-1], and advance[i] = advance[i+1] | ~v[i] for i < STAGES-1.
REQ-017 SHALL drive input_ready = advance[0] & ~flush, combinationally.
REQ-018 SHALL accept input when input_valid & input_ready; the transfer writes stage 0.
REQ-019 SHALL, on advance[i], load v[i] from the upstream valid (input_valid & input_ready for stage 0) and load d[i] only when that upstream valid is 1; otherwise d[i] holds.
REQ-020 SHALL hold v[i] and d[i] unchanged when advance[i] = 0.
REQ-021 SHALL produce output_valid exactly STAGES cycles after acceptance when output_ready stays 1 (one result per cycle, no bubbles).
REQ-022 SHALL keep out and output_valid stable while output_valid = 1 and output_ready = 0.
REQ-023 SHALL preserve order; no accepted item is dropped or duplicated except by flush or reset.
REQ-024 SHALL, when flush = 1, clear every v[i] at the next edge; the data registers hold, and the cycle's output transfer (if output_valid & output_ready) still counts as completed.
REQ-025 SHALL give flush priority over acceptance: no input is accepted in a flush cycle.
REQ-026 SHALL let a full pipeline with output_ready = 1 accept new input in the same cycle (simultaneous drain and fill).
REQ-027 SHALL wrap the addition modulo 2^WIDTH with no carry out, e.g. WIDTH=8, in_data 8'hF0 -> out 8'h1A.

Reset
REQ-028 SHALL, while rst_n = 0, clear all v[i] asynchronously, independent of clk.
REQ-029 SHALL clear all d[i] to 0 on reset; out resets to 0.
REQ-030 SHALL hold output_valid = 0 and occupancy = 0 throughout reset.
REQ-031 SHALL drive input_ready = 1 during reset, and SHALL treat no input as accepted while rst_n = 0.
REQ-032 SHALL discard all in-flight items when reset is asserted mid-operation; normal operation resumes on the first rising clk edge after rst_n deasserts.

Configuration
REQ-033 SHALL provide the occupancy feature under the macro SAMPLE_VALID_PIPE_OCC_EN.
REQ-034 SHALL, with SAMPLE_VALID_PIPE_OCC_EN defined, drive occupancy as a registered count: +1 on accept, -1 on output transfer, unchanged on both or neither, 0 after flush or reset.
REQ-035 SHALL, without SAMPLE_VALID_PIPE_OCC_EN, omit the occupancy port and the counter logic entirely; all other behaviour SHALL be identical.

Verification
REQ-036 SHALL cover streaming: STAGES=2, output_ready=1, inputs 0,1,2 on consecutive cycles -> out 42,43,44 on cycles 2,3,4 after the first acceptance, output_valid continuous.
REQ-037 SHALL cover backpressure: STAGES=3, fill 3 items with output_ready=0 -> input_ready=0 and occupancy=3, out stable; raise output_ready -> items drain in order, one per cycle.
REQ-038 SHALL cover a bubble: with output_valid=0 and stage 0 valid, output_ready=0 -> the item still advances into the empty downstream stage.
REQ-039 SHALL cover flush: 2 items in flight, assert flush with input_valid=1 -> input_ready=0, next cycle output_valid=0 and occupancy=0, the flushed input is never delivered.
REQ-040 SHALL cover wrap: WIDTH=8, in_data 8'hF0 -> out 8'h1A.
REQ-041 SHALL cover mid-operation reset: drop rst_n between clock edges with a full pipeline -> output_valid=0 and out=0 immediately; after release, the first new input appears after STAGES cycles.
